// File: rtl/bias_add_drain.sv
// Packs 8x32-bit bias-add result beats into words, buffers them in a FWFT FIFO and frames them.
// Latency: a beat pushed in cycle N is presented on out_valid/out_data in cycle N+1.
// Backpressure: out_ready stalls the FIFO; input has no backpressure, so a beat arriving at a full FIFO is dropped and flagged.
module bias_add_drain #(
  parameter int DEPTH = 8,
  parameter int LANES = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       start,
  input  logic [CNT_W-1:0]           frame_len,
  input  logic                       in_valid,
  input  logic [31:0]                in_0,
  input  logic [31:0]                in_1,
  input  logic [31:0]                in_2,
  input  logic [31:0]                in_3,
  input  logic [31:0]                in_4,
  input  logic [31:0]                in_5,
  input  logic [31:0]                in_6,
  input  logic [31:0]                in_7,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*32-1:0]        out_data,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = LANES * 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] dat;
  } entry_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   len_q;
  logic               ovf_q;
  logic               done_q;

  entry_t             mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      rd_ptr_q;
  logic [LW-1:0]      level_q;
  logic [LW-1:0]      level_d;

  logic [31:0]        lane [8];
  logic [DW-1:0]      in_word;
  logic               pop;
  logic               full;
  logic               beat;
  logic               push;
  logic [CNT_W-1:0]   cnt_inc;
  logic               last_beat;

  assign lane[0] = in_0;
  assign lane[1] = in_1;
  assign lane[2] = in_2;
  assign lane[3] = in_3;
  assign lane[4] = in_4;
  assign lane[5] = in_5;
  assign lane[6] = in_6;
  assign lane[7] = in_7;

  // in_k lands in bits [32k+31:32k] of the packed word
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i < 8) begin : g_map
      assign in_word[32*i +: 32] = lane[i];
    end else begin : g_pad
      assign in_word[32*i +: 32] = '0;
    end
  end

  assign pop       = (level_q != '0) && out_ready;
  assign full      = (level_q == LW'(DEPTH));
  assign beat      = (state_q == S_RUN) && in_valid && enable;
  // a full FIFO still takes the beat when the head leaves in the same cycle
  assign push      = beat && (!full || pop);
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_beat = (cnt_inc == len_q);

  // occupancy after this cycle's push/pop
  always_comb begin
    level_d = level_q + LW'(push) - LW'(pop);
  end

  // storage array: no reset needed, validity is tracked by level_q
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{last: last_beat, dat: in_word};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  // frame control: beat counting, overflow flag and the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (frame_len == '0) begin
              done_q <= 1'b1;
            end else begin
              len_q   <= frame_len;
              cnt_q   <= '0;
              ovf_q   <= 1'b0;
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (beat) begin
            // a dropped beat still counts toward the frame length
            cnt_q <= cnt_inc;
            if (!push) ovf_q <= 1'b1;
            if (last_beat) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // nothing is pushed here, so level_d==0 means the final pop is happening now
          if (level_d == '0) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid = (level_q != '0);
  assign out_data  = mem_q[rd_ptr_q].dat;
  assign out_last  = out_valid && mem_q[rd_ptr_q].last;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign overflow  = ovf_q;
  assign level     = level_q;

endmodule

// File: tb/tb_bias_add_drain.sv
// Scoreboard bench for bias_add_drain: the stimulus side runs a frame-level reference model
// and queues expected words; a negedge monitor compares every accepted output word.
module tb_bias_add_drain;
  localparam int DEPTH = 8;
  localparam int LANES = 8;
  localparam int CNT_W = 16;
  localparam int DW    = LANES * 32;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef logic [DW:0] item_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              enable = 1'b0;
  logic              start = 1'b0;
  logic [CNT_W-1:0]  frame_len = '0;
  logic              in_valid = 1'b0;
  logic [31:0]       ln [8];
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [LW-1:0]     level;

  int errors = 0;
  int checks = 0;
  int lasts_seen = 0;

  item_t exp_q[$];
  int    m_st;   // 0 idle, 1 collecting beats, 2 draining
  int    m_cnt;
  int    m_len;
  int    m_lvl;
  bit    m_ovf;
  bit    m_done;

  always #5 clk = ~clk;

  bias_add_drain #(.DEPTH(DEPTH), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .frame_len(frame_len),
    .in_valid(in_valid),
    .in_0(ln[0]), .in_1(ln[1]), .in_2(ln[2]), .in_3(ln[3]),
    .in_4(ln[4]), .in_5(ln[5]), .in_6(ln[6]), .in_7(ln[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .overflow(overflow), .level(level)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: every word the DUT hands over must be the oldest expected one
  always @(negedge clk) begin : mon
    item_t e;
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got data[31:0]=%0h last=%0b, expected no word", out_data[31:0], out_last);
      end else begin
        e = exp_q.pop_front();
        if ({out_last, out_data} !== e) begin
          errors++;
          $display("FAIL word: got last=%0b lane0=%0h lane7=%0h expected last=%0b lane0=%0h lane7=%0h",
                   out_last, out_data[31:0], out_data[255:224], e[DW], e[31:0], e[255:224]);
        end
      end
      if (out_last === 1'b1) lasts_seen++;
    end
  end

  task automatic rnd_lanes();
    for (int i = 0; i < 8; i++) ln[i] = $urandom;
  endtask

  // one clock of stimulus; the model predicts what the DUT shows after the edge
  task automatic step(input bit v, input bit e, input bit s, input int l, input bit r);
    item_t w;
    bit    pop, beat, push;
    in_valid  = v;
    enable    = e;
    start     = s;
    frame_len = CNT_W'(l);
    out_ready = r;
    w    = {1'b0, ln[7], ln[6], ln[5], ln[4], ln[3], ln[2], ln[1], ln[0]};
    pop  = (m_lvl > 0) && r;
    beat = (m_st == 1) && v && e;
    push = beat && ((m_lvl < DEPTH) || pop);
    m_done = 1'b0;
    if (push) begin
      w[DW] = (m_cnt + 1 == m_len);
      exp_q.push_back(w);
    end
    if (beat && !push) m_ovf = 1'b1;
    m_lvl = m_lvl + int'(push) - int'(pop);
    case (m_st)
      0: if (s) begin
           if (l == 0) m_done = 1'b1;
           else begin
             m_st = 1; m_cnt = 0; m_len = l; m_ovf = 1'b0;
           end
         end
      1: if (beat) begin
           m_cnt++;
           if (m_cnt == m_len) m_st = 2;
         end
      default: if (m_lvl == 0) begin
           m_st = 0; m_done = 1'b1;
         end
    endcase
    @(posedge clk); #1;
    start = 1'b0;
    check("level", 64'(level), 64'(m_lvl));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("busy", 64'(busy), 64'(m_st != 0));
    check("done", 64'(done), 64'(m_done));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && m_st != 0; i++) step(0, 1, 0, 0, 1);
    checks++;
    if (m_st != 0) begin
      errors++;
      $display("FAIL drain_timeout: model state %0d busy=%0b expected idle", m_st, busy);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; start = 1'b0; enable = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    m_st = 0; m_cnt = 0; m_len = 0; m_lvl = 0; m_ovf = 1'b0; m_done = 1'b0;
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
  endtask

  initial begin
    int l0;
    rnd_lanes();
    @(posedge clk); #1;
    do_reset();

    // frame of 4, no stall; lane0 = k, lane7 = k + 0x70
    l0 = lasts_seen;
    step(0, 1, 1, 4, 1);
    for (int k = 1; k <= 4; k++) begin
      rnd_lanes(); ln[0] = k; ln[7] = k + 32'h70;
      step(1, 1, 0, 0, 1);
    end
    drain();
    check("t1_lasts", 64'(lasts_seen - l0), 64'd1);
    check("t1_overflow", 64'(overflow), 64'd0);

    // backpressure: 10 beats into depth 8, last beat dropped
    l0 = lasts_seen;
    step(0, 1, 1, 10, 0);
    for (int k = 0; k < 10; k++) begin rnd_lanes(); step(1, 1, 0, 0, 0); end
    check("t2_level_sat", 64'(level), 64'(DEPTH));
    check("t2_overflow", 64'(overflow), 64'd1);
    drain();
    check("t2_lasts", 64'(lasts_seen - l0), 64'd0);
    check("t2_busy", 64'(busy), 64'd0);

    // full FIFO with simultaneous pop keeps every beat
    step(0, 1, 1, 30, 0);
    for (int k = 0; k < DEPTH; k++) begin rnd_lanes(); step(1, 1, 0, 0, 0); end
    for (int k = 0; k < 10; k++) begin rnd_lanes(); step(1, 1, 0, 0, 1); end
    check("t3_level_full", 64'(level), 64'(DEPTH));
    check("t3_no_overflow", 64'(overflow), 64'd0);
    for (int k = 0; k < 40 && m_st == 1; k++) begin rnd_lanes(); step(1, 1, 0, 0, 1); end
    drain();

    // enable gating mid-frame
    step(0, 1, 1, 2, 1);
    rnd_lanes(); step(1, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin rnd_lanes(); step(1, 0, 0, 0, 1); end
    check("t4_still_busy", 64'(busy), 64'd1);
    rnd_lanes(); step(1, 1, 0, 0, 1);
    drain();

    // zero-length start gives done without busy
    step(0, 1, 1, 0, 1);
    check("t5_zero_done", 64'(done), 64'd1);
    check("t5_zero_busy", 64'(busy), 64'd0);
    // start while busy is ignored
    step(0, 1, 1, 3, 1);
    rnd_lanes(); step(1, 1, 1, 1, 1);
    for (int k = 0; k < 2; k++) begin rnd_lanes(); step(1, 1, 0, 0, 1); end
    drain();
    // beats in IDLE are discarded
    for (int k = 0; k < 3; k++) begin rnd_lanes(); step(1, 1, 0, 0, 0); end
    check("t5_idle_level", 64'(level), 64'd0);
    // beats in DRAIN are discarded
    step(0, 1, 1, 2, 0);
    for (int k = 0; k < 5; k++) begin rnd_lanes(); step(1, 1, 0, 0, 0); end
    check("t5_drain_level", 64'(level), 64'd2);
    check("t5_drain_ovf", 64'(overflow), 64'd0);
    drain();

    // reset mid-frame, then a normal single-beat frame
    step(0, 1, 1, 20, 0);
    for (int k = 0; k < 5; k++) begin rnd_lanes(); step(1, 1, 0, 0, 0); end
    check("t6_level5", 64'(level), 64'd5);
    do_reset();
    l0 = lasts_seen;
    step(0, 1, 1, 1, 1);
    rnd_lanes(); step(1, 1, 0, 0, 1);
    drain();
    check("t6_lasts", 64'(lasts_seen - l0), 64'd1);

    // random frames with random backpressure
    for (int f = 0; f < 6; f++) begin
      step(0, 1, 1, int'($urandom_range(1, 14)), 1);
      for (int k = 0; k < 200 && m_st == 1; k++) begin
        rnd_lanes();
        step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 5) != 0), 0, 0,
             bit'($urandom_range(0, 1)));
      end
      drain();
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bias_add_drain.md
Name: bias_add_drain

Overview:
- Consumes the 8-lane, 32-bit result stream produced by the SFU bias-add stage; that stream has a valid strobe and no backpressure.
- Packs each result beat into a 256-bit word and buffers it in a first-word-fall-through (FWFT) FIFO.
- Emits the words on a valid/ready stream toward the writeback path and marks the final beat of each frame with a last flag.
- Frames the stream by a programmed beat count, drops and flags overflow, and pulses done when a frame has fully drained.

Parameters:
- DEPTH, 8, FIFO depth in beats; power of 2, at least 2.
- LANES, 8, number of 32-bit input lanes; the output word is LANES*32 bits.
- CNT_W, 16, width of the frame-length field and the beat counter.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  input gate; when low, in_valid is ignored (no push, no count).
- start  in  1  one-cycle pulse; latches frame_len and begins a frame. Ignored unless state is IDLE.
- frame_len  in  CNT_W  number of input beats in the frame; 0 means no-op.
- in_valid  in  1  result beat strobe from bias-add.
- in_0 .. in_7  in  32 each  result lanes; in_0 maps to out_data[31:0], in_k maps to out_data[32k+31:32k].
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  downstream accept.
- out_data  out  LANES*32  head-of-FIFO word.
- out_last  out  1  head word is the final beat of the frame.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a frame completes.
- overflow  out  1  sticky: a beat was dropped because the FIFO was full. Cleared by rst or by an accepted start.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values: state=IDLE, FIFO empty, and out_valid, out_last, busy, done, overflow and level all 0.
- Reset mid-frame discards all FIFO contents and the beat count; nothing is emitted afterwards.
- out_data is don't-care when out_valid=0.
- States:
  - IDLE: on start with frame_len>0, latch frame_len, clear the beat count and overflow, go to RUN. On start with frame_len=0, pulse done next cycle and stay in IDLE.
  - RUN: each cycle with in_valid and enable is one beat; the beat count increments by 1. When the beat count reaches frame_len, go to DRAIN.
  - DRAIN: further in_valid is ignored. When the FIFO is empty, pulse done for 1 cycle and go to IDLE.
- Push: a beat is written into the FIFO unless the FIFO is full with no pop in the same cycle.
- Full FIFO with a simultaneous pop (out_valid and out_ready): the push is accepted.
- Dropped beat: still counts toward frame_len, and overflow is set.
- The FIFO entry stores {last_tag, data}. last_tag=1 only on the beat whose count equals frame_len. If that beat is dropped, no out_last is emitted for the frame and done still pulses.
- Pop: occurs when out_valid and out_ready are both high. out_data and out_last are driven from the head entry (FWFT).
- Latency: a beat pushed in cycle N appears with out_valid=1 in cycle N+1.
- Throughput: 1 beat/cycle sustained when out_ready=1.
- Pointers wrap modulo DEPTH; level ranges 0..DEPTH.
- Beats arriving while in IDLE or DRAIN are not stored and do not set overflow.
- The done pulse is asserted in the cycle after the final pop is observed (FIFO empty in DRAIN).

Test Plan:
- Frame, no stall: frame_len=4, out_ready=1, 4 back-to-back beats with in_0=k, in_7=k+0x70 for k=1..4. Expect 4 output words, out_data[31:0]=1,2,3,4; out_last only on the 4th word; done 1 cycle after the last pop; overflow=0.
- Backpressure and overflow: DEPTH=8, frame_len=10, out_ready=0, 10 beats. Expect level saturates at 8 and overflow=1. Then out_ready=1: 8 words drain, none has out_last, done pulses, state returns to IDLE.
- Full with simultaneous pop: hold the FIFO at level=8 with out_ready=1 and a continuous beat stream. Expect no drops, overflow stays 0, level stays 8.
- Gating: enable=0 for 3 beats mid-frame with frame_len=2. Expect those beats are neither counted nor stored; the frame completes only after 2 beats with enable=1.
- Edge cases: start with frame_len=0 gives a done pulse with busy staying 0. start while busy is ignored. Beats in IDLE or DRAIN are discarded with no overflow.
- Reset mid-frame: assert rst at level=5 in RUN. Next cycle out_valid=0, level=0, busy=0. A new start with frame_len=1 then behaves normally.
